// File: rtl/execute_pkg.sv
// Shared execute-stage definitions: ALU operation encodings (also used by control) and datapath width.
package execute_pkg;

   localparam int EXEC_WIDTH = 16;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } aluOp_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with modulo-2^WIDTH arithmetic and a zero flag.
// Latency 0; no handshake, so no backpressure.
module alu
   import execute_pkg::*;
#(
   parameter int WIDTH = EXEC_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       aluOp,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // Carry-out and overflow are intentionally dropped; results simply wrap.
   always_comb begin
      result = '0;
      case (aluOp_e'(aluOp))
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// Execute stage: operand-B select, ALU, registered result and zero flag.
// Latency 1 cycle; one op per cycle, no stall input and no backpressure.
module execute
   import execute_pkg::*;
#(
   parameter int WIDTH = EXEC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] readData1,
   input  logic [WIDTH-1:0] readData2,
   input  logic [WIDTH-1:0] instant,
   input  logic             aluSrc,
   input  logic [1:0]       aluOp,
   output logic [WIDTH-1:0] aluOut,
   output logic             zero
);

   logic [WIDTH-1:0] operandB;
   logic [WIDTH-1:0] aluResult;
   logic             aluZero;

   assign operandB = aluSrc ? instant : readData2;

   alu #(
      .WIDTH (WIDTH)
   ) uAlu (
      .a      (readData1),
      .b      (operandB),
      .aluOp  (aluOp),
      .result (aluResult),
      .zero   (aluZero)
   );

   // Reset leaves zero set so the flag stays consistent with a cleared result.
   always_ff @(posedge clk) begin
      if (rst) begin
         aluOut <= '0;
         zero   <= 1'b1;
      end else begin
         aluOut <= aluResult;
         zero   <= aluZero;
      end
   end

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed vectors with literal expectations plus a per-cycle arithmetic model.
module tb_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] readData1;
   logic [15:0] readData2;
   logic [15:0] instant;
   logic        aluSrc;
   logic [1:0]  aluOp;
   logic [15:0] aluOut;
   logic        zero;

   int nChecks = 0;
   int nFails  = 0;

   logic [15:0] expOut;
   logic        expZero;
   logic        expValid = 1'b0;

   execute #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .readData1 (readData1),
      .readData2 (readData2),
      .instant   (instant),
      .aluSrc    (aluSrc),
      .aluOp     (aluOp),
      .aluOut    (aluOut),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Model: plain integer arithmetic reduced modulo 65536.
   function automatic logic [15:0] modelAlu(input int a, input int b, input int op);
      int r;
      case (op)
         0:       r = (a + b) % 65536;
         1:       r = (a - b + 65536) % 65536;
         2:       r = a & b;
         default: r = a | b;
      endcase
      return r[15:0];
   endfunction

   always @(posedge clk) begin
      logic [15:0] m;
      m = modelAlu(int'(readData1), aluSrc ? int'(instant) : int'(readData2), int'(aluOp));
      if (rst) begin
         expOut  <= 16'h0000;
         expZero <= 1'b1;
      end else begin
         expOut  <= m;
         expZero <= (m == 16'h0000);
      end
      expValid <= 1'b1;
   end

   always @(negedge clk) begin
      if (expValid) begin
         nChecks++;
         if (aluOut !== expOut || zero !== expZero) begin
            nFails++;
            $display("FAIL model: aluOut=%h zero=%b, expected aluOut=%h zero=%b at %0t",
                     aluOut, zero, expOut, expZero, $time);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] actOut, input logic actZ,
                        input logic [15:0] wantOut, input logic wantZ);
      nChecks++;
      if (actOut !== wantOut || actZ !== wantZ) begin
         nFails++;
         $display("FAIL %s: aluOut=%h zero=%b, expected aluOut=%h zero=%b",
                  name, actOut, actZ, wantOut, wantZ);
      end
   endtask

   // Drive one vector, clock it in, sample just after the edge.
   task automatic step(input string name, input logic r, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] imm, input logic src,
                       input logic [1:0] op, input logic [15:0] wantOut, input logic wantZ);
      rst = r; readData1 = d1; readData2 = d2; instant = imm; aluSrc = src; aluOp = op;
      @(posedge clk);
      #1;
      check(name, aluOut, zero, wantOut, wantZ);
   endtask

   initial begin
      rst = 1'b1; readData1 = 16'h1234; readData2 = 16'h0F0F; instant = 16'h00AA;
      aluSrc = 1'b0; aluOp = 2'b00;

      step("reset1",     1, 16'h1234, 16'h0F0F, 16'h00AA, 0, 2'b00, 16'h0000, 1);
      step("reset2",     1, 16'h1234, 16'h0F0F, 16'h00AA, 1, 2'b11, 16'h0000, 1);
      step("firstAdd",   0, 16'd5,    16'd5,    16'd0,    0, 2'b00, 16'd10,   0);
      step("regAdd",     0, 16'd10,   16'd20,   16'd0,    0, 2'b00, 16'd30,   0);
      step("immAdd",     0, 16'd10,   16'd20,   16'd3,    1, 2'b00, 16'd13,   0);
      step("immSub",     0, 16'd10,   16'd20,   16'd3,    1, 2'b01, 16'd7,    0);
      step("subZero",    0, 16'd20,   16'd20,   16'd3,    0, 2'b01, 16'd0,    1);
      step("andZero",    0, 16'h00F0, 16'h0F0F, 16'd0,    0, 2'b10, 16'h0000, 1);
      step("or",         0, 16'h00F0, 16'h0F0F, 16'd0,    0, 2'b11, 16'h0FFF, 0);
      step("addWrap",    0, 16'hFFFF, 16'd1,    16'd0,    0, 2'b00, 16'h0000, 1);
      step("subWrap",    0, 16'd0,    16'd9,    16'd1,    1, 2'b01, 16'hFFFF, 0);
      step("andImm",     0, 16'hABCD, 16'h0000, 16'h0FF0, 1, 2'b10, 16'h0BC0, 0);
      step("midReset",   1, 16'h7777, 16'h1111, 16'd0,    0, 2'b00, 16'h0000, 1);
      step("postReset",  0, 16'h7777, 16'h1111, 16'd0,    0, 2'b01, 16'h6666, 0);
      step("negImmAdd",  0, 16'd100,  16'd0,    16'hFFFE, 1, 2'b00, 16'd98,   0);
      step("srcIgnore",  0, 16'h8000, 16'h8000, 16'h1234, 0, 2'b00, 16'h0000, 1);

      // Back-to-back random vectors, checked every cycle against the model only.
      for (int i = 0; i < 60; i++) begin
         rst       = ($urandom_range(0, 19) == 0);
         readData1 = 16'($urandom);
         readData2 = ($urandom_range(0, 3) == 0) ? readData1 : 16'($urandom);
         instant   = 16'($urandom);
         aluSrc    = 1'($urandom);
         aluOp     = 2'($urandom);
         @(posedge clk);
         #1;
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the 16-bit MIPS-style datapath.
- Selects the second ALU operand: register readData2, or the already-extended 16-bit immediate `instant`.
- Performs the operation chosen by aluOp and produces aluOut plus a zero flag for branch decisions.
- Sits between decode (register read, immediate extension, control) and memory/writeback. Outputs are registered.

Parameters:
- WIDTH, 16, datapath width of operands and result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- readData1  input  WIDTH  ALU operand A (register rs)
- readData2  input  WIDTH  register rt; operand B when aluSrc=0
- instant  input  WIDTH  immediate, already sign-extended upstream; operand B when aluSrc=1
- aluSrc  input  1  operand B select: 0 = readData2, 1 = instant
- aluOp  input  2  operation select
- aluOut  output  WIDTH  registered ALU result
- zero  output  1  registered flag, 1 when the result is all zeros

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: when rst=1 at a rising clk, aluOut <= 0 and zero <= 1, since the flag is consistent with a zero result. Reset overrides all inputs.
- Operand B = aluSrc ? instant : readData2. This mux is combinational.
- aluOp encoding:
  - 00 ADD: A + B
  - 01 SUB: A - B
  - 10 AND: A & B
  - 11 OR: A | B
- Arithmetic is WIDTH-bit modulo 2^WIDTH.
  - Carry-out and overflow are discarded; no exception or flag for them.
  - Results wrap, e.g. 0xFFFF + 1 = 0x0000, 0 - 1 = 0xFFFF.
- zero = (result == 0). It is computed from the same result that is registered into aluOut, so the two always agree.
- Latency: inputs sampled at rising edge N appear on aluOut/zero after edge N and hold until the next edge.
- Throughput: one operation per cycle. There is no handshake and no stall input.
- Reset asserted mid-stream: the outputs clear on that edge. The first result after reset deasserts comes from the inputs present at the first non-reset edge.
- X/unknown inputs are not sanitised. Upstream guarantees defined values while not in reset.

Decomposition:
- Shared package: aluOp encoding constants (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11) and the WIDTH default. The same encodings are reused by the control unit.
- One sub-module is natural: `alu`, a purely combinational block taking A, B and aluOp and producing result and zero.
- The execute module wraps `alu` with the operand-B mux and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> aluOut=0, zero=1. Release rst and apply readData1=5, readData2=5, aluSrc=0, aluOp=00 -> aluOut=10, zero=0 after one edge.
- Register ADD: readData1=10, readData2=20, instant=0, aluSrc=0, aluOp=00 -> aluOut=30, zero=0.
- Immediate ADD: readData1=10, readData2=20, instant=3, aluSrc=1, aluOp=00 -> aluOut=13, zero=0.
- Immediate SUB: readData1=10, readData2=20, instant=3, aluSrc=1, aluOp=01 -> aluOut=7. Then readData1=20, readData2=20, aluSrc=0, aluOp=01 -> aluOut=0, zero=1.
- Logic ops: readData1=0x00F0, readData2=0x0F0F, aluSrc=0.
  - aluOp=10 -> aluOut=0x0000, zero=1
  - aluOp=11 -> aluOut=0x0FFF, zero=0
- Wrap-around:
  - readData1=0xFFFF, readData2=1, ADD -> aluOut=0x0000, zero=1
  - readData1=0, instant=1, aluSrc=1, SUB -> aluOut=0xFFFF, zero=0
  - Back-to-back changes on every edge -> each result appears exactly one cycle after its inputs.
